// File: rtl/cmos_pkg.sv
// Shared FSM type, default geometry and counter helpers for the DVP capture front end.
package cmos_pkg;

    localparam int unsigned DefHPixels    = 640;
    localparam int unsigned DefVLines     = 480;
    localparam int unsigned DefSkipFrames = 10;
    localparam int unsigned CntW          = 11;

    localparam logic [CntW-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitVs,
        StSkip,
        StCapture,
        StFrameEnd
    } cap_state_e;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_in_sync.sv
// Two-flop synchronizer for one asynchronous camera line, with registered rise/fall pulses.
module cam_in_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, hist_q, rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            rise_q  <= sync2_q & ~hist_q;
            fall_q  <= ~sync2_q & hist_q;
        end
    end

    // The history register lines up with the edge pulses, so it serves as the level.
    assign level_o = hist_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cmos_capture.sv
// DVP camera capture: pairs synchronized camera bytes into RGB565 words for the write FIFO,
// skipping settling frames and flagging overflow and line/frame length errors.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int unsigned H_PIXELS    = DefHPixels,
    parameter int unsigned V_LINES     = DefVLines,
    parameter int unsigned SKIP_FRAMES = DefSkipFrames
) (
    input  logic        clk_100M_i,
    input  logic        rst_100i,
    input  logic        cap_en_i,
    input  logic        cam_pclk_i,
    input  logic        cam_vsync_i,
    input  logic        cam_href_i,
    input  logic [7:0]  cam_data_i,
    input  logic        fifo_full_i,
    output logic [15:0] pix_data_o,
    output logic        pix_wr_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic [7:0]  frame_cnt_o,
    output logic        overflow_o,
    output logic        len_err_o
);

    localparam logic [CntW-1:0] HPix  = CntW'(H_PIXELS);
    localparam logic [CntW-1:0] VLin  = CntW'(V_LINES);
    localparam logic [CntW-1:0] SkipN = CntW'(SKIP_FRAMES);

    logic pc_level, pc_rise, pc_fall;
    logic hr_level, hr_rise, hr_fall;
    logic vs_level, vs_rise, vs_fall;

    cam_in_sync u_sync_pclk (
        .clk_i   (clk_100M_i),
        .rst_i   (rst_100i),
        .async_i (cam_pclk_i),
        .level_o (pc_level),
        .rise_o  (pc_rise),
        .fall_o  (pc_fall)
    );

    cam_in_sync u_sync_href (
        .clk_i   (clk_100M_i),
        .rst_i   (rst_100i),
        .async_i (cam_href_i),
        .level_o (hr_level),
        .rise_o  (hr_rise),
        .fall_o  (hr_fall)
    );

    cam_in_sync u_sync_vsync (
        .clk_i   (clk_100M_i),
        .rst_i   (rst_100i),
        .async_i (cam_vsync_i),
        .level_o (vs_level),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    logic unused_sync;
    assign unused_sync = pc_level ^ pc_fall ^ vs_level;

    // Data takes the same three-register path as the control edges.
    logic [7:0] data_s1_q, data_s2_q, data_q;

    cap_state_e      state_q, state_d;
    logic [CntW-1:0] skip_cnt_q, skip_cnt_d;
    logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CntW-1:0] line_cnt_q, line_cnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic [15:0]     pix_data_q, pix_data_d;
    logic            pix_wr_q, pix_wr_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            overflow_q, overflow_d;
    logic            len_err_q, len_err_d;

    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        phase_d       = phase_q;
        hi_byte_d     = hi_byte_q;
        pix_data_d    = pix_data_q;
        pix_wr_d      = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        overflow_d    = overflow_q;
        len_err_d     = len_err_q;

        unique case (state_q)
            StIdle: begin
                skip_cnt_d = '0;
                pix_cnt_d  = '0;
                line_cnt_d = '0;
                phase_d    = 1'b0;
                overflow_d = 1'b0;
                len_err_d  = 1'b0;
                if (cap_en_i) begin
                    state_d = StWaitVs;
                end
            end

            StWaitVs: begin
                if (!cap_en_i) begin
                    state_d = StIdle;
                end else if (vs_fall) begin
                    if (skip_cnt_q < SkipN) begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                        state_d    = StSkip;
                    end else begin
                        frame_start_d = 1'b1;
                        pix_cnt_d     = '0;
                        line_cnt_d    = '0;
                        phase_d       = 1'b0;
                        state_d       = StCapture;
                    end
                end
            end

            StSkip: begin
                if (!cap_en_i) begin
                    state_d = StIdle;
                end else if (vs_rise) begin
                    state_d = StWaitVs;
                end
            end

            StCapture: begin
                // An HREF edge wins over a coincident PCLK edge.
                if (hr_rise) begin
                    phase_d = 1'b0;
                    if (pc_rise) begin
                        hi_byte_d = data_q;
                        phase_d   = 1'b1;
                    end
                end else if (hr_fall) begin
                    if (phase_q || (pix_cnt_q != HPix)) begin
                        len_err_d = 1'b1;
                    end
                    pix_cnt_d  = '0;
                    line_cnt_d = sat_inc(line_cnt_q);
                end else if (pc_rise && hr_level) begin
                    if (!phase_q) begin
                        hi_byte_d = data_q;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        pix_cnt_d = sat_inc(pix_cnt_q);
                        if ((pix_cnt_q < HPix) && (line_cnt_q < VLin)) begin
                            if (!fifo_full_i) begin
                                pix_wr_d   = 1'b1;
                                pix_data_d = {hi_byte_q, data_q};
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                end
                if (vs_rise) begin
                    state_d = StFrameEnd;
                end
            end

            StFrameEnd: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 8'd1;
                if (line_cnt_q != VLin) begin
                    len_err_d = 1'b1;
                end
                line_cnt_d = '0;
                pix_cnt_d  = '0;
                state_d    = cap_en_i ? StWaitVs : StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100M_i) begin
        if (rst_100i) begin
            data_s1_q     <= '0;
            data_s2_q     <= '0;
            data_q        <= '0;
            state_q       <= StIdle;
            skip_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            phase_q       <= 1'b0;
            hi_byte_q     <= '0;
            pix_data_q    <= '0;
            pix_wr_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            overflow_q    <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            data_s1_q     <= cam_data_i;
            data_s2_q     <= data_s1_q;
            data_q        <= data_s2_q;
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            phase_q       <= phase_d;
            hi_byte_q     <= hi_byte_d;
            pix_data_q    <= pix_data_d;
            pix_wr_q      <= pix_wr_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            overflow_q    <= overflow_d;
            len_err_q     <= len_err_d;
        end
    end

    assign pix_data_o    = pix_data_q;
    assign pix_wr_o      = pix_wr_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign overflow_o    = overflow_q;
    assign len_err_o     = len_err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Scoreboard bench for cmos_capture on a reduced 4x3 frame geometry with 2 skip frames.
module tb_cmos_capture;

    localparam int unsigned HP = 4;
    localparam int unsigned VL = 3;
    localparam int unsigned SK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  cam_data;
    logic        fifo_full;
    logic [15:0] pix_data;
    logic        pix_wr;
    logic        frame_start;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        overflow;
    logic        len_err;

    cmos_capture #(
        .H_PIXELS    (HP),
        .V_LINES     (VL),
        .SKIP_FRAMES (SK)
    ) dut (
        .clk_100M_i    (clk),
        .rst_100i      (rst),
        .cap_en_i      (cap_en),
        .cam_pclk_i    (pclk),
        .cam_vsync_i   (vsync),
        .cam_href_i    (href),
        .cam_data_i    (cam_data),
        .fifo_full_i   (fifo_full),
        .pix_data_o    (pix_data),
        .pix_wr_o      (pix_wr),
        .frame_start_o (frame_start),
        .frame_done_o  (frame_done),
        .frame_cnt_o   (frame_cnt),
        .overflow_o    (overflow),
        .len_err_o     (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_start  = 0;
    int   n_done   = 0;
    int   exp_start_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pix_data"}, pix_data, 0);
        check_eq({tag, "_pix_wr"}, pix_wr, 0);
        check_eq({tag, "_frame_start"}, frame_start, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_frame_cnt"}, frame_cnt, 0);
        check_eq({tag, "_overflow"}, overflow, 0);
        check_eq({tag, "_len_err"}, len_err, 0);
    endtask

    // Pop one expectation per write; data and arrival cycle must both match.
    always @(negedge clk) begin
        exp_t e;
        if (pix_wr) begin
            check_eq("wr_expected", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("pix_data", pix_data, e.data);
                check_eq("pix_latency", cyc, e.cyc);
            end
        end
        if (frame_start) begin
            n_start++;
            check_eq("start_latency", cyc, exp_start_cyc);
        end
        if (frame_done) n_done++;
    end

    // capt: words of this frame are expected to be written; -1 disables a line option.
    task automatic send_frame(input int n_lines, input bit capt, input int odd_line,
                              input int full_line, input int en_off_line, input int rst_line);
        bit         live;
        int         nb;
        logic [7:0] hi;
        exp_t       e;
        live = capt;
        hi   = 8'h00;
        @(negedge clk);
        vsync         = 1'b0;
        exp_start_cyc = cyc + 4;
        repeat (6) @(negedge clk);
        for (int l = 0; l < n_lines; l++) begin
            if (l == rst_line) begin
                rst = 1'b1;
                @(negedge clk);
                check_all_zero("midrst");
                rst  = 1'b0;
                live = 1'b0;
            end
            if (l == en_off_line) cap_en = 1'b0;
            fifo_full = (l == full_line);
            href      = 1'b1;
            nb        = (l == odd_line) ? 2 * HP + 1 : 2 * HP;
            for (int b = 0; b < nb; b++) begin
                if (l == 0 && b == 0)      cam_data = 8'h12;
                else if (l == 0 && b == 1) cam_data = 8'h34;
                else                       cam_data = 8'($urandom_range(0, 255));
                pclk = 1'b0;
                repeat (2) @(negedge clk);
                pclk = 1'b1;
                if (b % 2 == 0) begin
                    hi = cam_data;
                end else if (live && l < VL && (b / 2) < HP && l != full_line) begin
                    e.data = {hi, cam_data};
                    e.cyc  = cyc + 4;
                    sb_q.push_back(e);
                end
                repeat (2) @(negedge clk);
            end
            href = 1'b0;
            pclk = 1'b0;
            repeat (8) @(negedge clk);
            fifo_full = 1'b0;
        end
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        cap_en    = 1'b0;
        pclk      = 1'b0;
        vsync     = 1'b1;
        href      = 1'b0;
        cam_data  = 8'h00;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        cap_en = 1'b1;

        // Two settling frames, then two clean captured frames.
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        check_eq("skip_no_done", n_done, 0);
        send_frame(VL, 1'b1, -1, -1, -1, -1);
        send_frame(VL, 1'b1, -1, -1, -1, -1);
        check_eq("clean_frame_cnt", frame_cnt, 2);
        check_eq("clean_len_err", len_err, 0);
        check_eq("clean_overflow", overflow, 0);
        check_eq("clean_sb_drained", sb_q.size(), 0);

        // Odd byte count on line 1.
        send_frame(VL, 1'b1, 1, -1, -1, -1);
        check_eq("odd_line_len_err", len_err, 1);
        check_eq("odd_line_frame_cnt", frame_cnt, 3);

        // Dropping enable while waiting for VSYNC returns to idle and clears flags.
        cap_en = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("idle_len_err_clr", len_err, 0);
        cap_en = 1'b1;

        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL - 1, 1'b1, -1, -1, -1, -1);
        check_eq("short_frame_len_err", len_err, 1);
        check_eq("short_frame_cnt", frame_cnt, 4);

        // FIFO full for a whole line: those words are dropped.
        send_frame(VL, 1'b1, -1, 1, -1, -1);
        check_eq("full_overflow", overflow, 1);
        check_eq("full_frame_cnt", frame_cnt, 5);
        send_frame(VL, 1'b1, -1, -1, -1, -1);
        check_eq("overflow_sticky", overflow, 1);

        // Enable falls mid-frame: frame completes, then idle.
        send_frame(VL, 1'b1, -1, -1, 1, -1);
        check_eq("en_off_frame_cnt", frame_cnt, 7);
        check_eq("en_off_overflow_clr", overflow, 0);
        check_eq("en_off_len_err_clr", len_err, 0);
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        check_eq("disabled_frame_cnt", frame_cnt, 7);
        check_eq("disabled_done_cnt", n_done, 7);

        // Reset mid-capture abandons the frame; capture resumes after new skip frames.
        cap_en = 1'b1;
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL, 1'b1, -1, -1, -1, 1);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_no_done", n_done, 7);
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL, 1'b0, -1, -1, -1, -1);
        send_frame(VL, 1'b1, -1, -1, -1, -1);
        check_eq("resume_frame_cnt", frame_cnt, 1);
        check_eq("resume_len_err", len_err, 0);
        check_eq("resume_overflow", overflow, 0);

        repeat (10) @(negedge clk);
        check_eq("total_done", n_done, 8);
        check_eq("total_start", n_start, 9);
        check_eq("final_sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
